// File: rtl/robot_pkg.sv
// robot_pkg: controller state codes, opcodes, done status codes and scheduler state type
package robot_pkg;
  typedef enum logic [2:0] {C_IDLE, C_FORWARD, C_BACKWARD, C_LEFT, C_RIGHT, C_STOP, C_ERROR, C_RECOVER} ctrl_state_t;
  typedef enum logic [1:0] {OP_FWD, OP_BWD, OP_LEFT, OP_RIGHT} op_t;
  typedef enum logic [1:0] {DS_OK, DS_OBST, DS_ERR, DS_FLUSH} done_status_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sched_state_t;
endpackage

// File: rtl/robot_rr_arb2.sv
// robot_rr_arb2: two-way round-robin arbiter whose last-grant pointer moves only on accept
module robot_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q, last_d;
  always_comb begin
    grant = {valid[1] & (~valid[0] | ~last_q), valid[0] & (~valid[1] | last_q)};
    last_d = advance ? grant[1] : last_q;
  end
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
endmodule

// File: rtl/robot_cmd_sched.sv
// robot_cmd_sched: round-robin timed motion-command scheduler with abort and completion status
module robot_cmd_sched
  import robot_pkg::*;
#(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [DUR_W-1:0] req0_dur,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [DUR_W-1:0] req1_dur,
  input  logic [2:0]       fsm_state,
  input  logic             flush,
  output logic             move_fwd,
  output logic             move_bwd,
  output logic             turn_left,
  output logic             turn_right,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [1:0]       done_status
);
  sched_state_t state_q, state_d;
  logic id_q, id_d, first_q, first_d;
  logic [DUR_W-1:0] cnt_q, cnt_d, dur_in;
  logic [1:0] status_q, status_d, grant, rdy, op_in;
  logic [3:0] mot_q, mot_d;
  logic blocked, adv, sel, stop_hit, is_err, exit_run;
  robot_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .valid({req1_valid, req0_valid}),
    .advance(adv),
    .grant(grant)
  );
  always_comb begin
    blocked = fsm_state == C_ERROR || fsm_state == C_RECOVER;
    rdy = (state_q == S_IDLE && !blocked) ? grant : 2'b00;
    adv = |rdy;
    sel = rdy[1];
    op_in = sel ? req1_op : req0_op;
    dur_in = sel ? req1_dur : req0_dur;
    is_err = fsm_state == C_ERROR;
    stop_hit = fsm_state == C_STOP && !first_q;
    exit_run = is_err || stop_hit || flush || cnt_q == '0;
    state_d = state_q;
    id_d = id_q;
    cnt_d = cnt_q;
    first_d = first_q;
    status_d = status_q;
    mot_d = mot_q;
    if (state_q == S_IDLE && adv) begin
      state_d = S_RUN;
      id_d = sel;
      cnt_d = dur_in == '0 ? '0 : dur_in - DUR_W'(1);
      first_d = 1'b1;
      mot_d = 4'b0001 << op_in;
    end else if (state_q == S_RUN) begin
      first_d = 1'b0;
      cnt_d = cnt_q - DUR_W'(1);
      if (exit_run) begin
        state_d = S_DONE;
        mot_d = '0;
        status_d = is_err ? DS_ERR : stop_hit ? DS_OBST : flush ? DS_FLUSH : DS_OK;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q <= 1'b0;
      cnt_q <= '0;
      first_q <= 1'b0;
      status_q <= DS_OK;
      mot_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      status_q <= status_d;
      mot_q <= mot_d;
    end
  end
  assign {turn_right, turn_left, move_bwd, move_fwd} = mot_q;
  assign {req1_ready, req0_ready} = rdy;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign done_id = done & id_q;
  assign done_status = done ? status_q : 2'b00;
endmodule

// File: tb/tb_robot_cmd_sched.sv
// tb_robot_cmd_sched: table-driven and directed self-checking bench for robot_cmd_sched
module tb_robot_cmd_sched;
  typedef struct {
    logic rs, v0, v1;
    logic [1:0] o0, o1;
    logic [7:0] d0, d1;
    logic [2:0] fs;
    logic fl, r0, r1;
    logic [3:0] mt;
    logic bz, dn, id;
    logic [1:0] st;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_dur = '0, req1_dur = '0;
  logic [2:0] fsm_state = '0;
  logic req0_ready, req1_ready, move_fwd, move_bwd, turn_left, turn_right, busy, done, done_id;
  logic [1:0] done_status;
  logic [3:0] mot;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[$];
  assign mot = {turn_right, turn_left, move_bwd, move_fwd};
  robot_cmd_sched #(.DUR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_dur(req0_dur),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_dur(req1_dur),
    .fsm_state(fsm_state), .flush(flush),
    .move_fwd(move_fwd), .move_bwd(move_bwd), .turn_left(turn_left), .turn_right(turn_right),
    .busy(busy), .done(done), .done_id(done_id), .done_status(done_status)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input int rs, v0, v1, o0, o1, d0, d1, fs, fl, r0, r1, mt, bz, dn, id, st);
    vec_t x;
    x.rs = 1'(rs); x.v0 = 1'(v0); x.v1 = 1'(v1); x.o0 = 2'(o0); x.o1 = 2'(o1);
    x.d0 = 8'(d0); x.d1 = 8'(d1); x.fs = 3'(fs); x.fl = 1'(fl);
    x.r0 = 1'(r0); x.r1 = 1'(r1); x.mt = 4'(mt); x.bz = 1'(bz); x.dn = 1'(dn); x.id = 1'(id); x.st = 2'(st);
    return x;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, a, b, input logic [1:0] o0, o1, input logic [7:0] d0, d1,
                       input logic [2:0] fs, input logic fl);
    @(negedge clk);
    rst = r; req0_valid = a; req1_valid = b; req0_op = o0; req1_op = o1;
    req0_dur = d0; req1_dur = d1; fsm_state = fs; flush = fl;
    #1;
  endtask
  task automatic idle(input logic [2:0] fs, input logic fl);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, fs, fl);
  endtask
  task automatic run_cmd(input logic id, input logic [1:0] op, input logic [7:0] dur, input int exp_n, input string nm);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    drive(1'b0, !id, id, op, op, dur, dur, 3'd0, 1'b0);
    chk({nm, "_rdy"}, id ? req1_ready : req0_ready, 1);
    for (int k = 0; k < 300 && !seen; k++) begin
      idle(3'd0, 1'b0);
      if (done) seen = 1'b1;
      else if (mot == (4'b0001 << op)) n++;
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_drive_cycles"}, n, exp_n);
    chk({nm, "_id"}, done_id, id);
    chk({nm, "_status"}, done_status, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 1,0,0,0,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,2,1,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,0,1,1,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,8,1,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,0,1,1,1,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 1,0,0,0,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,2,1,0,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,0,0,1,1,0,0));
    tv.push_back(mk(0,1,1,1,3,1,1,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,8,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,1,1,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,0,0,0,3,0,0,0, 1,0,0,0,0,0,0));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0,0,0,0,0,0,0,1,0, 0,0,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,1,0,2,0,2,6,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,1,0,2,0,2,6,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,1,0,2,0,2,7,0, 0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,1,0,2,0,2,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,3,0, 0,0,4,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,3,0, 0,0,4,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,1,1,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 3'd0, 1'b0);
    foreach (tv[i]) begin
      drive(tv[i].rs, tv[i].v0, tv[i].v1, tv[i].o0, tv[i].o1, tv[i].d0, tv[i].d1, tv[i].fs, tv[i].fl);
      chk($sformatf("vec%0d", i), {req0_ready, req1_ready, mot, busy, done, done_id, done_status},
          {tv[i].r0, tv[i].r1, tv[i].mt, tv[i].bz, tv[i].dn, tv[i].id, tv[i].st});
    end
    drive(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 8'd10, 8'd0, 3'd0, 1'b0);
    chk("stop_rdy", req0_ready, 1);
    idle(3'd5, 1'b0);
    chk("stop_run1_left", turn_left, 1);
    idle(3'd5, 1'b0);
    chk("stop_run2_left", turn_left, 1);
    idle(3'd5, 1'b0);
    chk("stop_drop", {mot, done, done_id, done_status}, {4'h0, 1'b1, 1'b0, 2'd1});
    idle(3'd5, 1'b0);
    chk("stop_idle", {busy, done}, 0);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 8'd5, 8'd5, 3'd0, 1'b0);
    chk("errfl_rdy", req1_ready, 1);
    idle(3'd6, 1'b1);
    chk("errfl_fwd", move_fwd, 1);
    idle(3'd0, 1'b0);
    chk("errfl_done", {mot, done, done_id, done_status}, {4'h0, 1'b1, 1'b1, 2'd2});
    idle(3'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 8'd2, 8'd2, 3'd0, 1'b0);
    idle(3'd0, 1'b0);
    chk("flush_run1_bwd", move_bwd, 1);
    idle(3'd0, 1'b1);
    chk("flush_last_bwd", move_bwd, 1);
    idle(3'd0, 1'b0);
    chk("flush_done", {mot, done, done_id, done_status}, {4'h0, 1'b1, 1'b0, 2'd3});
    idle(3'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 8'd10, 8'd10, 3'd0, 1'b0);
    idle(3'd5, 1'b0);
    idle(3'd5, 1'b1);
    chk("stopfl_run2_right", turn_right, 1);
    idle(3'd0, 1'b0);
    chk("stopfl_done", {done, done_status}, {1'b1, 2'd1});
    idle(3'd0, 1'b0);
    run_cmd(1'b0, 2'd0, 8'd0, 1, "dur0");
    run_cmd(1'b1, 2'd3, 8'd255, 255, "dur255");
    drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'd20, 8'd20, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) idle(3'd0, 1'b0);
    chk("rst_pre_fwd", move_fwd, 1);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0, 3'd0, 1'b0);
    idle(3'd0, 1'b0);
    chk("rst_outputs", {req0_ready, req1_ready, mot, busy, done, done_id, done_status}, 0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(3'd0, 1'b0);
      if (done) seen = 1'b1;
    end
    chk("rst_no_done", seen, 0);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 8'd1, 8'd1, 3'd0, 1'b0);
    chk("rst_tie_req0", {req0_ready, req1_ready}, 2'b10);
    for (int k = 0; k < 3; k++) idle(3'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
